// File: rtl/bus_xfer_if.sv
// Handshake and bus signals between the transfer controller (master) and the datapath (slave).
interface bus_xfer_if;
    logic       req;
    logic [2:0] src;
    logic [2:0] dst;
    logic [7:0] imm;
    logic [7:0] bus_in;
    logic [7:0] oe_n;
    logic [7:0] ie_n;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] last_data;

    modport master (
        input  req, src, dst, imm, bus_in,
        output oe_n, ie_n, bus_out, bus_oe, busy, done, err, last_data
    );

    modport slave (
        output req, src, dst, imm, bus_in,
        input  oe_n, ie_n, bus_out, bus_oe, busy, done, err, last_data
    );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Shared-bus transfer sequencer: drives one source, strobes one destination load,
// holds the source one extra cycle, and records every transferred byte.
module bus_xfer_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input logic        clk,
    input logic        rst_n,
    bus_xfer_if.master bif
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned UNIT_W = 3;
    localparam int unsigned DATA_W = 8;
    localparam logic [UNIT_W-1:0] IMM_UNIT = UNIT_W'(7);

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, HOLD} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [UNIT_W-1:0]   src_q, src_d;
    logic [UNIT_W-1:0]   dst_q, dst_d;
    logic [DATA_W-1:0]   oe_n_q, oe_n_d;
    logic [DATA_W-1:0]   ie_n_q, ie_n_d;
    logic [DATA_W-1:0]   bus_out_q, bus_out_d;
    logic                bus_oe_q, bus_oe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   last_data_q, last_data_d;
    logic                accept_window;

    // Next state plus next registered strobes, derived from where we will be next cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        dst_d       = dst_q;
        bus_out_d   = bus_out_q;
        last_data_d = last_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        oe_n_d      = '1;
        ie_n_d      = '1;
        bus_oe_d    = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            IDLE: ;
            DRIVE: begin
                if (cnt_q <= CNT_W'(1)) state_d = LOAD;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            LOAD: begin
                state_d     = HOLD;
                last_data_d = bif.bus_in;
            end
            HOLD: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // The last HOLD cycle doubles as an acceptance slot so back-to-back transfers lose no cycle.
        accept_window = (state_q == IDLE) || (state_q == HOLD);
        if (accept_window && bif.req) begin
            if (bif.src == bif.dst) begin
                err_d = 1'b1;
            end else begin
                state_d = DRIVE;
                src_d   = bif.src;
                dst_d   = bif.dst;
                cnt_d   = CNT_W'(SETTLE_CYCLES);
                if (bif.src == IMM_UNIT) bus_out_d = bif.imm;
            end
        end

        busy_d = (state_d != IDLE);
        if (busy_d) begin
            if (src_d == IMM_UNIT) bus_oe_d      = 1'b1;
            else                   oe_n_d[src_d] = 1'b0;
        end
        if ((state_d == LOAD) && (dst_d != IMM_UNIT)) ie_n_d[dst_d] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            oe_n_q      <= '1;
            ie_n_q      <= '1;
            bus_out_q   <= '0;
            bus_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            oe_n_q      <= oe_n_d;
            ie_n_q      <= ie_n_d;
            bus_out_q   <= bus_out_d;
            bus_oe_q    <= bus_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            last_data_q <= last_data_d;
        end
    end

    assign bif.oe_n      = oe_n_q;
    assign bif.ie_n      = ie_n_q;
    assign bif.bus_out   = bus_out_q;
    assign bif.bus_oe    = bus_oe_q;
    assign bif.busy      = busy_q;
    assign bif.done      = done_q;
    assign bif.err       = err_q;
    assign bif.last_data = last_data_q;
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl: one instance at SETTLE_CYCLES=1, one at 3 for back-to-back.
module tb_bus_xfer_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    bus_xfer_if ifa ();
    bus_xfer_if ifb ();

    bus_xfer_ctrl #(.SETTLE_CYCLES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bif(ifa));
    bus_xfer_ctrl #(.SETTLE_CYCLES(3)) dut_b (.clk(clk), .rst_n(rst_n), .bif(ifb));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic inv(input string tag, input logic [7:0] oe, input logic [7:0] ie, input logic boe);
        logic [7:0] lo_oe;
        logic [7:0] lo_ie;
        lo_oe = ~oe;
        lo_ie = ~ie;
        chk({tag, "_oe_one_low"}, 8'($onehot0(lo_oe)), 8'd1);
        chk({tag, "_ie_one_low"}, 8'($onehot0(lo_ie)), 8'd1);
        chk({tag, "_oe_ie_same_unit"}, lo_oe & lo_ie, 8'h00);
        chk({tag, "_ie_without_source"}, 8'((lo_ie != 8'h00) && (lo_oe == 8'h00) && !boe), 8'd0);
        chk({tag, "_bit7_high"}, 8'({oe[7], ie[7]}), 8'h03);
    endtask

    // Advance n clocks; sample #1 after each rising edge and check the bus invariants on both DUTs.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            inv("a", ifa.oe_n, ifa.ie_n, ifa.bus_oe);
            inv("b", ifb.oe_n, ifb.ie_n, ifb.bus_oe);
        end
    endtask

    initial begin
        ifa.req = 1'b0; ifa.src = 3'd0; ifa.dst = 3'd0; ifa.imm = 8'h00; ifa.bus_in = 8'h00;
        ifb.req = 1'b0; ifb.src = 3'd0; ifb.dst = 3'd0; ifb.imm = 8'h00; ifb.bus_in = 8'h00;

        // Reset values
        tick(2);
        chk("rst_oe_n", ifa.oe_n, 8'hFF);
        chk("rst_ie_n", ifa.ie_n, 8'hFF);
        chk("rst_bus_out", ifa.bus_out, 8'h00);
        chk("rst_bus_oe", 8'(ifa.bus_oe), 8'd0);
        chk("rst_busy", 8'(ifa.busy), 8'd0);
        chk("rst_done", 8'(ifa.done), 8'd0);
        chk("rst_err", 8'(ifa.err), 8'd0);
        chk("rst_last_data", ifa.last_data, 8'h00);
        rst_n = 1'b1;
        tick(1);

        // Register transfer 0 -> 1
        ifa.req = 1'b1; ifa.src = 3'd0; ifa.dst = 3'd1; ifa.bus_in = 8'h5A;
        tick(1);
        ifa.req = 1'b0;
        chk("reg_drive_oe", ifa.oe_n, 8'hFE);
        chk("reg_drive_ie", ifa.ie_n, 8'hFF);
        chk("reg_drive_busy", 8'(ifa.busy), 8'd1);
        chk("reg_drive_done", 8'(ifa.done), 8'd0);
        tick(1);
        chk("reg_load_oe", ifa.oe_n, 8'hFE);
        chk("reg_load_ie", ifa.ie_n, 8'hFD);
        tick(1);
        chk("reg_hold_oe", ifa.oe_n, 8'hFE);
        chk("reg_hold_ie", ifa.ie_n, 8'hFF);
        chk("reg_last_data", ifa.last_data, 8'h5A);
        chk("reg_hold_done", 8'(ifa.done), 8'd0);
        tick(1);
        chk("reg_end_oe", ifa.oe_n, 8'hFF);
        chk("reg_end_done", 8'(ifa.done), 8'd1);
        chk("reg_end_busy", 8'(ifa.busy), 8'd0);
        tick(1);
        chk("reg_done_pulse", 8'(ifa.done), 8'd0);

        // Immediate transfer 7 -> 2, imm changed after acceptance
        ifa.req = 1'b1; ifa.src = 3'd7; ifa.dst = 3'd2; ifa.imm = 8'hC3;
        tick(1);
        ifa.req = 1'b0; ifa.imm = 8'h00;
        chk("imm_drive_boe", 8'(ifa.bus_oe), 8'd1);
        chk("imm_drive_bus", ifa.bus_out, 8'hC3);
        chk("imm_drive_oe", ifa.oe_n, 8'hFF);
        tick(1);
        chk("imm_load_ie", ifa.ie_n, 8'hFB);
        chk("imm_load_bus", ifa.bus_out, 8'hC3);
        chk("imm_load_oe", ifa.oe_n, 8'hFF);
        tick(1);
        chk("imm_hold_ie", ifa.ie_n, 8'hFF);
        chk("imm_hold_boe", 8'(ifa.bus_oe), 8'd1);
        chk("imm_hold_bus", ifa.bus_out, 8'hC3);
        tick(1);
        chk("imm_end_boe", 8'(ifa.bus_oe), 8'd0);
        chk("imm_end_done", 8'(ifa.done), 8'd1);

        // Rejected requests: 4/4 then 7/7
        ifa.req = 1'b1; ifa.src = 3'd4; ifa.dst = 3'd4;
        tick(1);
        chk("rej44_err", 8'(ifa.err), 8'd1);
        chk("rej44_busy", 8'(ifa.busy), 8'd0);
        chk("rej44_oe", ifa.oe_n, 8'hFF);
        chk("rej44_ie", ifa.ie_n, 8'hFF);
        ifa.src = 3'd7; ifa.dst = 3'd7;
        tick(1);
        ifa.req = 1'b0;
        chk("rej77_err", 8'(ifa.err), 8'd1);
        chk("rej77_boe", 8'(ifa.bus_oe), 8'd0);
        tick(1);
        chk("rej_err_pulse", 8'(ifa.err), 8'd0);

        // Capture-only 3 -> 7
        ifa.req = 1'b1; ifa.src = 3'd3; ifa.dst = 3'd7; ifa.bus_in = 8'h81;
        tick(1);
        ifa.req = 1'b0;
        chk("cap_drive_oe", ifa.oe_n, 8'hF7);
        tick(1);
        chk("cap_load_ie", ifa.ie_n, 8'hFF);
        tick(1);
        chk("cap_last_data", ifa.last_data, 8'h81);
        tick(1);
        chk("cap_done", 8'(ifa.done), 8'd1);

        // Request raised during LOAD is ignored
        ifa.req = 1'b1; ifa.src = 3'd0; ifa.dst = 3'd1;
        tick(1);
        ifa.req = 1'b0;
        tick(1);
        ifa.req = 1'b1; ifa.src = 3'd5; ifa.dst = 3'd6;
        tick(1);
        ifa.req = 1'b0;
        chk("busy_ign_hold_oe", ifa.oe_n, 8'hFE);
        tick(1);
        chk("busy_ign_done", 8'(ifa.done), 8'd1);
        chk("busy_ign_oe", ifa.oe_n, 8'hFF);
        chk("busy_ign_busy", 8'(ifa.busy), 8'd0);

        // Asynchronous reset in the middle of LOAD
        ifa.req = 1'b1; ifa.src = 3'd0; ifa.dst = 3'd1; ifa.bus_in = 8'hAA;
        tick(1);
        ifa.req = 1'b0;
        tick(1);
        chk("midrst_pre_ie", ifa.ie_n, 8'hFD);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ie", ifa.ie_n, 8'hFF);
        chk("midrst_oe", ifa.oe_n, 8'hFF);
        chk("midrst_busy", 8'(ifa.busy), 8'd0);
        chk("midrst_last_data", ifa.last_data, 8'h00);
        tick(1);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("midrst_no_done", 8'(ifa.done), 8'd0);
        end

        // Back-to-back with SETTLE_CYCLES=3 and req held high: one acceptance every 5 cycles
        ifb.req = 1'b1; ifb.src = 3'd0; ifb.dst = 3'd1; ifb.bus_in = 8'h3C;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            chk($sformatf("b2b_done_%0d", k), 8'(ifb.done), 8'((k == 6) || (k == 11)));
            chk($sformatf("b2b_ie_%0d", k), ifb.ie_n, ((k == 4) || (k == 9)) ? 8'hFD : 8'hFF);
            chk($sformatf("b2b_oe_%0d", k), ifb.oe_n, 8'hFE);
            chk($sformatf("b2b_busy_%0d", k), 8'(ifb.busy), 8'd1);
        end
        ifb.req = 1'b0;
        tick(4);
        chk("b2b_last_data", ifb.last_data, 8'h3C);
        chk("b2b_final_done", 8'(ifb.done), 8'd1);
        tick(1);
        chk("b2b_idle_busy", 8'(ifb.busy), 8'd0);

        // Random request stream; invariants are checked every cycle inside tick
        for (int k = 0; k < 300; k++) begin
            ifa.req    = 1'($urandom_range(0, 1));
            ifa.src    = 3'($urandom_range(0, 7));
            ifa.dst    = 3'($urandom_range(0, 7));
            ifa.imm    = 8'($urandom_range(0, 255));
            ifa.bus_in = 8'($urandom_range(0, 255));
            ifb.req    = 1'($urandom_range(0, 1));
            ifb.src    = 3'($urandom_range(0, 7));
            ifb.dst    = 3'($urandom_range(0, 7));
            tick(1);
        end
        ifa.req = 1'b0;
        ifb.req = 1'b0;
        tick(8);
        chk("rand_a_idle", 8'(ifa.busy), 8'd0);
        chk("rand_b_idle", 8'(ifb.busy), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
